// File: rtl/line_buffer_rng.sv
// Ping-pong pair of line buffers for 3x3 window filters, plus a
// free-running LFSR that supplies a pseudo-random brightness offset.
module line_buffer_rng #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb0,
    output logic [DATA_WIDTH-1:0] doutb1,
    output logic [5:0]            brightness
);

    localparam int          DEPTH = 1 << ADDR_WIDTH;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic [DATA_WIDTH-1:0] mem0 [DEPTH];
    logic [DATA_WIDTH-1:0] mem1 [DEPTH];
    logic [15:0]           lfsr;
    logic                  fb;

    // Contents survive reset; only a write landing while reset is held is lost.
    always_ff @(posedge clk or negedge n_rst) begin
        if (n_rst) begin
            if (wea) begin
                mem0[addra] <= dina;
            end else begin
                mem1[addra] <= dina;
            end
        end
    end

    // Non-blocking read of the old word gives read-first on a collision.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            doutb0 <= '0;
            doutb1 <= '0;
        end else begin
            doutb0 <= mem0[addrb];
            doutb1 <= mem1[addrb];
        end
    end

    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lfsr <= SEED;
        end else if (lfsr == 16'h0000) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], fb};
        end
    end

    assign brightness = lfsr[5:0];

endmodule

// File: tb/tb_line_buffer_rng.sv
// Randomized bench for line_buffer_rng against a behavioural model
// of the two buffers and the LFSR sequence.
module tb_line_buffer_rng;

    localparam int DW    = 24;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          wea = 1'b0;
    logic [AW-1:0] addra = '0;
    logic [DW-1:0] dina = '0;
    logic [AW-1:0] addrb = '0;
    logic [DW-1:0] doutb0;
    logic [DW-1:0] doutb1;
    logic [5:0]    brightness;

    int pass_cnt = 0;
    int total_cnt = 0;

    line_buffer_rng #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .wea(wea),
        .addra(addra),
        .dina(dina),
        .addrb(addrb),
        .doutb0(doutb0),
        .doutb1(doutb1),
        .brightness(brightness)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [DW-1:0] m0 [DEPTH];
    logic [DW-1:0] m1 [DEPTH];
    bit            v0 [DEPTH];
    bit            v1 [DEPTH];
    logic [DW-1:0] e0 = '0;
    logic [DW-1:0] e1 = '0;
    bit            k0 = 1'b1;
    bit            k1 = 1'b1;
    logic [15:0]   ml = 16'hACE1;
    int            edges = 0;
    bit            zero_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        // Taps 16,14,13,11 of the polynomial sit at bit mask 16'hB400.
        if (s == 16'h0) return 16'hACE1;
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    always @(negedge n_rst) begin
        e0 = '0; e1 = '0; k0 = 1'b1; k1 = 1'b1;
        ml = 16'hACE1; edges = 0;
    end

    always @(posedge clk) begin
        if (n_rst) begin
            k0 = v0[addrb]; e0 = m0[addrb];
            k1 = v1[addrb]; e1 = m1[addrb];
            if (wea) begin
                m0[addra] = dina; v0[addra] = 1'b1;
            end else begin
                m1[addra] = dina; v1[addra] = 1'b1;
            end
            ml = lfsr_next(ml);
            if (ml == 16'h0) zero_seen = 1'b1;
            edges++;
        end
    end

    // Single compare process
    always @(negedge clk) begin
        if (k0) chk("doutb0", 32'(doutb0), 32'(e0));
        if (k1) chk("doutb1", 32'(doutb1), 32'(e1));
        chk("brightness", 32'(brightness), 32'(ml[5:0]));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        addra = 12'd5;
        repeat (3) step();
        chk("rst_doutb0", 32'(doutb0), 32'h0);
        chk("rst_doutb1", 32'(doutb1), 32'h0);
        chk("rst_bright", 32'(brightness), 32'h21);

        n_rst = 1'b1;
        step();
        chk("rel1_bright", 32'(brightness), 32'h03);
        step();
        chk("rel2_bright", 32'(brightness), 32'h07);
        chk("model_lfsr2", 32'(ml), 32'hB387);

        wea = 1'b1; addra = 12'd5; dina = 24'hABCDEF;
        step();
        wea = 1'b0; dina = 24'h123456; addrb = 12'd5;
        step();
        chk("sel_buf0", 32'(doutb0), 32'hABCDEF);
        chk("sel_buf1_old", 32'(doutb1), 32'h0);
        addra = 12'd200; dina = 24'h0;
        step();
        chk("sel2_buf1", 32'(doutb1), 32'h123456);
        chk("sel2_buf0", 32'(doutb0), 32'hABCDEF);

        wea = 1'b1; addra = 12'd7; dina = 24'h111111;
        step();
        dina = 24'h222222; addrb = 12'd7;
        step();
        chk("coll_old", 32'(doutb0), 32'h111111);
        addra = 12'd8; dina = 24'h0;
        step();
        chk("coll_new", 32'(doutb0), 32'h222222);

        wea = 1'b1;
        for (int c = 0; c < 2200; c++) begin
            addra = AW'(c); dina = DW'(c);
            step();
        end
        wea = 1'b0;
        for (int c = 0; c < 2200; c++) begin
            addra = AW'(c); dina = DW'($urandom);
            addrb = AW'(c + 2);
            step();
            if (c <= 2197) chk("pingpong", 32'(doutb0), 32'(c + 2));
        end

        wea = 1'b1; addra = 12'd4095; dina = 24'hF0F0F0;
        step();
        addra = 12'd0; dina = 24'h0A0B0C;
        step();
        wea = 1'b0; addra = 12'd10; addrb = 12'd4095;
        step();
        chk("wrap_4095", 32'(doutb0), 32'hF0F0F0);
        addrb = 12'd0;
        step();
        chk("wrap_0", 32'(doutb0), 32'h0A0B0C);

        addrb = 12'd3;
        #1 n_rst = 1'b0;
        #1;
        chk("async_doutb0", 32'(doutb0), 32'h0);
        chk("async_bright", 32'(brightness), 32'h21);
        wea = 1'b1; addra = 12'd5; dina = 24'hFFFFFF;
        step();
        wea = 1'b0; addra = 12'd11; addrb = 12'd5;
        n_rst = 1'b1;
        step();
        chk("retain_buf0", 32'(doutb0), 32'd5);

        while (edges < 65535) begin
            wea = 1'($urandom);
            addra = AW'($urandom_range(0, 63));
            addrb = AW'($urandom_range(0, 63));
            dina = DW'($urandom);
            step();
        end
        chk("period_lfsr", 32'(ml), 32'hACE1);
        chk("period_bright", 32'(brightness), 32'h21);
        chk("never_zero", 32'(zero_seen), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
